// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, transmitter state encoding and
// the bit-period counter width helper.
package uart_pkg;

    localparam int CLK_FREQ             = 50_000_000;
    localparam int BAUD                 = 115_200;
    localparam int DEFAULT_CLKS_PER_BIT = CLK_FREQ / BAUD;

    localparam logic [2:0] LAST_BIT_IDX = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } tx_state_e;

    function automatic int cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte-transmit request/status bundle between a client and uart_byte_tx.
interface uart_byte_tx_if;

    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_serial;

    modport master (
        output tx_data, tx_en, tx_start,
        input  tx_busy, tx_done, tx_serial
    );

    modport slave (
        input  tx_data, tx_en, tx_start,
        output tx_busy, tx_done, tx_serial
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count
// for one cycle; restart holds it at zero.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int              CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]   TC = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc   = (r_cnt == TC);
    assign o_tick = w_tc && !i_restart;

    // Terminal count reloads zero directly, so the count never passes TC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || w_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 UART byte transmitter with a level start request and a DONE handshake
// that needs tx_start to drop before another frame can be accepted.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input logic           clk,
    input logic           rst_n,
    uart_byte_tx_if.slave bus
);

    tx_state_e  r_state;
    tx_state_e  w_state_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic [2:0] r_bit_idx;
    logic [2:0] w_bit_idx_nxt;
    logic       r_tx_serial;
    logic       r_tx_busy;
    logic       r_tx_done;
    logic       w_serial_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_restart;
    logic       w_tick;

    // Counter runs only while a bit is on the line, so each bit starts at zero.
    assign w_restart = !((r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP));

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    // Next state and next line level; outputs are registered from these.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_serial_nxt  = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (bus.tx_en && bus.tx_start) begin
                    w_state_nxt   = ST_START;
                    w_shift_nxt   = bus.tx_data;
                    w_bit_idx_nxt = 3'd0;
                    w_serial_nxt  = 1'b0;
                end else begin
                    w_serial_nxt  = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt  = ST_DATA;
                    w_serial_nxt = r_shift[0];
                end else begin
                    w_serial_nxt = 1'b0;
                end
            end
            ST_DATA: begin
                w_serial_nxt = r_shift[0];
                if (w_tick) begin
                    if (r_bit_idx == LAST_BIT_IDX) begin
                        w_state_nxt  = ST_STOP;
                        w_serial_nxt = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_serial_nxt  = r_shift[1];
                    end
                end else begin
                    w_serial_nxt = r_shift[0];
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_DONE: begin
                if (!bus.tx_start) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_shift_nxt   = 8'h00;
                w_bit_idx_nxt = 3'd0;
                w_serial_nxt  = 1'b1;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // State, datapath and output registers; reset forces the line high at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= 8'h00;
            r_bit_idx   <= 3'd0;
            r_tx_serial <= 1'b1;
            r_tx_busy   <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_tx_serial <= w_serial_nxt;
            r_tx_busy   <= w_busy_nxt;
            r_tx_done   <= w_done_nxt;
        end
    end

    assign bus.tx_serial = r_tx_serial;
    assign bus.tx_busy   = r_tx_busy;
    assign bus.tx_done   = r_tx_done;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx at four clocks per bit; expected line levels
// are hand-written frame vectors, position p in bit p (start = bit 0).
module tb_uart_byte_tx;

    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    uart_byte_tx_if u_if ();

    uart_byte_tx #(
        .CLKS_PER_BIT (N)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_line(input string tag, input logic ser, input logic busy, input logic done);
        chk_val({tag, "_serial"}, {31'd0, u_if.tx_serial}, {31'd0, ser});
        chk_val({tag, "_busy"},   {31'd0, u_if.tx_busy},   {31'd0, busy});
        chk_val({tag, "_done"},   {31'd0, u_if.tx_done},   {31'd0, done});
    endtask

    // hold=1 keeps tx_start/tx_en high throughout; hold=0 drops them mid-frame.
    task automatic send_frame(input string tag, input logic [7:0] data, input logic [9:0] frame,
                              input logic hold, input logic [7:0] late_data);
        u_if.tx_data  = data;
        u_if.tx_en    = 1'b1;
        u_if.tx_start = 1'b1;
        step();
        for (int c = 0; c < 10 * N; c++) begin
            chk_line(tag, frame[c / N], 1'b1, 1'b0);
            if (c == 4) u_if.tx_data = late_data;
            if (!hold && c == 2) u_if.tx_start = 1'b0;
            if (!hold && c == 6) u_if.tx_en = 1'b0;
            step();
        end
        chk_line({tag, "_end"}, 1'b1, 1'b1, 1'b1);
        if (hold) begin
            for (int c = 0; c < 12; c++) begin
                step();
                chk_line({tag, "_held"}, 1'b1, 1'b1, 1'b1);
            end
            u_if.tx_start = 1'b0;
        end
        step();
        chk_line({tag, "_idle"}, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        u_if.tx_data  = 8'h00;
        u_if.tx_en    = 1'b0;
        u_if.tx_start = 1'b0;
        repeat (3) step();
        chk_line("reset", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        // Start requested while disabled must be ignored.
        u_if.tx_data  = 8'hA5;
        u_if.tx_start = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step();
            chk_line("disabled", 1'b1, 1'b0, 1'b0);
        end

        send_frame("a5_hold", 8'hA5, 10'b1101001010, 1'b1, 8'hA5);
        send_frame("3c_late", 8'h3C, 10'b1001111000, 1'b0, 8'hFF);
        send_frame("b2b_00",  8'h00, 10'b1000000000, 1'b0, 8'h00);
        send_frame("b2b_ff",  8'hFF, 10'b1111111110, 1'b0, 8'hFF);

        // Reset at edge k+17, in the middle of data bit 3 of an all-zero byte.
        u_if.tx_data  = 8'h00;
        u_if.tx_en    = 1'b1;
        u_if.tx_start = 1'b1;
        step();
        repeat (16) step();
        chk_line("pre_rst", 1'b0, 1'b1, 1'b0);
        rst_n         = 1'b0;
        u_if.tx_start = 1'b0;
        step();
        chk_line("mid_rst", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step();
            chk_line("post_rst", 1'b1, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434 (50 MHz / 115200 baud), meaning clk cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, rising-edge system clock.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port tx_data, input, 8, byte to transmit, sampled only at accept.
REQ-005 SHALL have port tx_en, input, 1, transmitter enable; gates accept.
REQ-006 SHALL have port tx_start, input, 1, level request to send tx_data.
REQ-007 SHALL have port tx_busy, output, 1, high from accept until return to IDLE.
REQ-008 SHALL have port tx_done, output, 1, frame-complete flag, held until tx_start drops.
REQ-009 SHALL have port tx_serial, output, 1, registered UART line, idle high, 8N1, LSB first.

Function
REQ-010 SHALL implement states IDLE, START, DATA, STOP, DONE.
REQ-011 IDLE: accept SHALL occur on an edge where tx_en=1 and tx_start=1; that edge latches tx_data into the shift register, clears the bit-cycle and bit-index counters, enters START, drives tx_serial=0 and tx_busy=1.
REQ-012 IDLE with tx_start=1 and tx_en=0 SHALL be ignored: no state change, tx_serial stays 1.
REQ-013 START SHALL hold tx_serial=0 for exactly CLKS_PER_BIT cycles, then enter DATA driving bit 0.
REQ-014 DATA SHALL drive bit i (i=0..7) for exactly CLKS_PER_BIT cycles each; after bit 7 it SHALL enter STOP, driving tx_serial=1.
REQ-015 STOP SHALL hold tx_serial=1 for exactly CLKS_PER_BIT cycles, then enter DONE and set tx_done=1.
REQ-016 Timing, with accept at edge k: tx_serial=bit i from edge k+(1+i)*CLKS_PER_BIT; stop bit from edge k+9*CLKS_PER_BIT; tx_done=1 from edge k+10*CLKS_PER_BIT.
REQ-017 DONE SHALL keep tx_done=1, tx_busy=1, and tx_serial=1 while tx_start=1; on the first edge with tx_start=0 it SHALL return to IDLE, clearing tx_done and tx_busy.
REQ-018 A tx_start level held across a completed frame SHALL NOT start a second frame; re-arm requires tx_start=0 seen in DONE.
REQ-019 Changes on tx_data, tx_en, or tx_start during START/DATA/STOP SHALL NOT affect the frame in flight.
REQ-020 Deasserting tx_en mid-frame SHALL NOT abort the frame.
REQ-021 The bit-cycle counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and count 0..CLKS_PER_BIT-1 with no wrap glitch.
REQ-022 The bit index SHALL be 3 bits and exit DATA at index 7 terminal count.
REQ-023 Unreachable state encodings SHALL return to IDLE on the next edge, with tx_serial=1.

Reset
REQ-024 On an edge with rst_n=0, the block SHALL set state=IDLE, tx_serial=1, tx_busy=0, tx_done=0, and clear all counters and the shift register.
REQ-025 Reset asserted mid-frame SHALL abort the frame, with the line high on that same edge; no tx_done SHALL be produced for the aborted frame.

Structure
REQ-026 Shared package uart_pkg SHALL hold the state encoding constants and the default CLKS_PER_BIT derivation (CLK_FREQ=50_000_000, BAUD=115200).
REQ-027 One sub-module uart_baud_tick SHALL provide the bit-period counter: a restart input and a one-cycle terminal-count output.
REQ-028 Total RTL SHALL be a single FSM plus the shift register and the counter instance, with no FIFO.

Verification
REQ-029 With CLKS_PER_BIT=4, tx_data=0xA5, and tx_en=tx_start=1 for one accept, tx_serial SHALL be 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, and tx_done=1 at edge k+40.
REQ-030 With tx_start held high through completion, tx_done SHALL stay 1 and no second start bit SHALL appear; after tx_start=0, tx_busy=0 on the next edge.
REQ-031 With tx_start=1 and tx_en=0 for 100 cycles, tx_serial SHALL stay 1, tx_busy=0, and tx_done=0.
REQ-032 If tx_data changes 0x3C to 0xFF at edge k+5, the transmitted bits SHALL still be 0x3C.
REQ-033 With rst_n=0 at edge k+17 (mid DATA), tx_serial=1, tx_busy=0, and tx_done=0 SHALL hold at that edge, and no tx_done SHALL follow.
REQ-034 Sending 0x00 then 0xFF back-to-back via the DONE handshake SHALL produce correct frames with exactly one idle cycle or more between them.
